freq_meas: RTL and testbench

Square-wave frequency meter, the measurement counterpart of the phase-2 DDS square-wave generator. It samples an external square wave, counts system clocks between rising edges and during the high phase, and converts the period to a frequency in Hz using a sequential divider. The result feeds the frequency-tracking loop, and lets the bench close the loop on the generator output.

---
 rtl/freq_meas_if.sv | 21 ++
 rtl/freq_meas.sv | 187 ++++++++++++++++++
 tb/tb_freq_meas.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/freq_meas_if.sv
// Measurement bus for freq_meas: square-wave input and the published period/high/frequency results.
interface freq_meas_if;
  localparam int unsigned W = 32;

  logic         sig_in;
  logic [W-1:0] period_val;
  logic [W-1:0] high_val;
  logic [W-1:0] freq_val;
  logic         meas_valid;
  logic         timeout;

  modport master (
    output sig_in,
    input  period_val, high_val, freq_val, meas_valid, timeout
  );

  modport slave (
    input  sig_in,
    output period_val, high_val, freq_val, meas_valid, timeout
  );
endinterface

// File: rtl/freq_meas.sv
// Square-wave frequency meter: period/high-time counting with loss-of-signal detection.
// Define FREQ_MEAS_DIV_EN to compile in the sequential divider that produces freq_val.
module freq_meas #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  freq_meas_if.slave  bus
);

  localparam int unsigned W      = 32;
  localparam logic [W-1:0] TO_VAL = W'(TIMEOUT_CYC);

  if (CLK_FREQ == 0 || TIMEOUT_CYC == 0) begin : g_cfg_check
    $error("freq_meas: CLK_FREQ and TIMEOUT_CYC must be non-zero");
  end

`ifdef FREQ_MEAS_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEAS = 2'd1, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEAS = 2'd1} state_t;
`endif

  state_t       r_state, w_state_nxt;
  logic         r_sync1, r_sync2, r_prev;
  logic         w_rise, w_fall;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_hi_cap;
  logic [W-1:0] r_period, r_high;
  logic         r_valid, r_timeout;
  logic         w_publish, w_lost;
  logic [W-1:0] w_pub_per;

  // Two-flop synchronizer plus edge-detect flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  // Cycles since last rising edge; saturation doubles as the loss-of-signal marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_cnt <= '0;
    else if (w_rise)          r_cnt <= W'(1);
    else if (r_cnt != TO_VAL) r_cnt <= r_cnt + W'(1);
  end

`ifdef FREQ_MEAS_DIV_EN
  localparam logic [W-1:0] DIVIDEND = W'(CLK_FREQ);

  logic         w_div_go;
  logic [W-1:0] r_per_cap, r_rem, r_quo, r_freq;
  logic [4:0]   r_iter;
  logic [W:0]   w_part, w_diff;
  logic         w_qbit;
  logic [W-1:0] w_rem_nxt, w_quo_nxt;

  // Restoring divider: dividend bits shift out of r_quo's top as quotient bits shift in
  assign w_part    = {r_rem, r_quo[W-1]};
  assign w_diff    = w_part - {1'b0, r_per_cap};
  assign w_qbit    = ~w_diff[W];
  assign w_rem_nxt = w_qbit ? w_diff[W-1:0] : w_part[W-1:0];
  assign w_quo_nxt = {r_quo[W-2:0], w_qbit};
  assign w_pub_per = r_per_cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per_cap <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_iter    <= '0;
    end else if (w_div_go) begin
      r_per_cap <= r_cnt;
      r_rem     <= '0;
      r_quo     <= DIVIDEND;
      r_iter    <= '0;
    end else if (r_state == S_DIV) begin
      r_rem     <= w_rem_nxt;
      r_quo     <= w_quo_nxt;
      r_iter    <= r_iter + 5'd1;
    end
  end
`else
  assign w_pub_per = r_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and publish/loss strobes; a rise always beats a timeout
  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_lost      = 1'b0;
`ifdef FREQ_MEAS_DIV_EN
    w_div_go    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (w_rise) begin
`ifdef FREQ_MEAS_DIV_EN
          w_state_nxt = S_DIV;
          w_div_go    = 1'b1;
`else
          w_publish   = 1'b1;
`endif
        end else if (r_cnt == TO_VAL) begin
          w_lost      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef FREQ_MEAS_DIV_EN
      S_DIV: begin
        if (r_iter == 5'd31) begin
          w_publish   = 1'b1;
          w_state_nxt = S_MEAS;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // High time is only captured while measuring; IDLE forgets it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_hi_cap <= '0;
    else if (r_state == S_IDLE)            r_hi_cap <= '0;
    else if (r_state == S_MEAS && w_fall)  r_hi_cap <= r_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
`ifdef FREQ_MEAS_DIV_EN
      r_freq    <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_publish) begin
        r_period  <= w_pub_per;
        r_high    <= r_hi_cap;
        r_valid   <= 1'b1;
        r_timeout <= 1'b0;
`ifdef FREQ_MEAS_DIV_EN
        r_freq    <= w_quo_nxt;
`endif
      end else if (w_lost) begin
        r_period  <= '0;
        r_high    <= '0;
        r_valid   <= 1'b1;
        r_timeout <= 1'b1;
`ifdef FREQ_MEAS_DIV_EN
        r_freq    <= '0;
`endif
      end
    end
  end

  assign bus.period_val = r_period;
  assign bus.high_val   = r_high;
  assign bus.meas_valid = r_valid;
  assign bus.timeout    = r_timeout;
`ifdef FREQ_MEAS_DIV_EN
  assign bus.freq_val   = r_freq;
`else
  assign bus.freq_val   = '0;
`endif

endmodule

// File: tb/tb_freq_meas.sv
// Scoreboard bench for freq_meas: directed square waves, expectations queued at each rising edge.
module tb_freq_meas;
  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned TO_CYC = 1000;
`ifdef FREQ_MEAS_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam longint LAT = DIV_EN ? 35 : 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  freq_meas_if bus ();

  freq_meas #(.CLK_FREQ(CLK_HZ), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] per;
    logic [31:0] hi;
    logic [31:0] freq;
    logic        to;
    bit          chk_hi;
    longint      at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  bit     m_started = 1'b0;
  bit     m_chk_hi  = 1'b1;
  longint m_prev    = 0;
  longint m_acc     = -1000;
  longint m_hi      = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, longint'(bus.period_val), 0);
    chk({tag, "_high"},   longint'(bus.high_val),   0);
    chk({tag, "_freq"},   longint'(bus.freq_val),   0);
    chk({tag, "_valid"},  longint'(bus.meas_valid), 0);
    chk({tag, "_timeout"},longint'(bus.timeout),    0);
  endtask

  function automatic logic [31:0] exp_freq(input longint p);
    if (DIV_EN) return 32'(longint'(CLK_HZ) / p);
    return 32'd0;
  endfunction

  // A rise ends the running period; it is reported unless it lands while the divider is busy
  task automatic do_rise();
    longint n;
    exp_t   e;
    n = cyc;
    bus.sig_in = 1'b1;
    if (m_started && (!DIV_EN || n >= m_acc + 33)) begin
      e.per    = 32'(n - m_prev);
      e.hi     = 32'(m_hi);
      e.freq   = exp_freq(n - m_prev);
      e.to     = 1'b0;
      e.chk_hi = m_chk_hi;
      e.at     = n + LAT;
      q.push_back(e);
      m_acc = n;
    end
    m_started = 1'b1;
    m_prev    = n;
  endtask

  task automatic do_fall();
    longint n;
    n = cyc;
    bus.sig_in = 1'b0;
    if (m_started && !(DIV_EN && n >= m_acc + 1 && n <= m_acc + 32))
      m_hi = n - m_prev;
  endtask

  task automatic run_periods(input int n, input int p, input int h);
    for (int i = 0; i < n; i++) begin
      do_rise();
      repeat (h) @(negedge clk);
      do_fall();
      repeat (p - h) @(negedge clk);
    end
  endtask

  // Hold low past the timeout; expect one all-zero report with timeout set
  task automatic lose_signal();
    exp_t e;
    e.per    = '0;
    e.hi     = '0;
    e.freq   = '0;
    e.to     = 1'b1;
    e.chk_hi = 1'b1;
    e.at     = m_prev + longint'(TO_CYC) + 3;
    q.push_back(e);
    m_started = 1'b0;
    m_hi      = 0;
    repeat (TO_CYC + 100) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && bus.meas_valid) begin
      if (q.size() == 0) begin
        chk("stray_valid", longint'(bus.meas_valid), 0);
      end else begin
        mon_e = q.pop_front();
        chk("period", longint'(bus.period_val), longint'(mon_e.per));
        if (mon_e.chk_hi) chk("high", longint'(bus.high_val), longint'(mon_e.hi));
        chk("freq",    longint'(bus.freq_val), longint'(mon_e.freq));
        chk("timeout", longint'(bus.timeout),  longint'(mon_e.to));
        chk("latency", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sig_in = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.sig_in = ~bus.sig_in;
    end
    chk_zero("rst_hold");
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_zero("post_rst");

    run_periods(4, 500, 250);
    run_periods(4, 100, 30);
    m_chk_hi = !DIV_EN;
    run_periods(10, 20, 10);
    m_chk_hi = 1'b1;
    lose_signal();

    run_periods(10, 200, 100);
    lose_signal();
    run_periods(3, 200, 100);
    chk("timeout_cleared", longint'(bus.timeout), 0);

    // Reset ten cycles into the division: the pending result must never appear
    do_rise();
    repeat (13) @(negedge clk);
    rst = 1'b0;
    if (DIV_EN) void'(q.pop_back());
    #1;
    chk_zero("rst_div");
    m_started = 1'b0;
    m_hi      = 0;
    m_acc     = -1000;
    @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);

    run_periods(4, 50, 20);
    if (!DIV_EN) run_periods(10, 7, 3);
    repeat (60) @(negedge clk);
    chk("sb_empty", longint'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
